// File: rtl/aes_stream_ctrl_if.sv
// rtl/aes_stream_ctrl_if.sv - word streams, AES-core operands and status of aes_stream_ctrl
interface aes_stream_ctrl_if;
  logic [31:0]  s_tdata;
  logic         s_tvalid;
  logic         s_tready;
  logic         s_tlast;
  logic [31:0]  m_tdata;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;
  logic         aes_en;
  logic [31:0]  aes_cmd;
  logic [127:0] aes_key;
  logic [127:0] aes_in_blk;
  logic [127:0] aes_out_blk;
  logic         aes_en_o;
  logic         busy;
  logic         frame_err;

  modport master (
    input  s_tdata, s_tvalid, s_tlast, m_tready, aes_out_blk, aes_en_o,
    output s_tready, m_tdata, m_tvalid, m_tlast, aes_en, aes_cmd, aes_key,
           aes_in_blk, busy, frame_err
  );

  modport slave (
    output s_tdata, s_tvalid, s_tlast, m_tready, aes_out_blk, aes_en_o,
    input  s_tready, m_tdata, m_tvalid, m_tlast, aes_en, aes_cmd, aes_key,
           aes_in_blk, busy, frame_err
  );
endinterface

// File: rtl/aes_stream_ctrl.sv
// rtl/aes_stream_ctrl.sv - command-frame glue between a DMA word stream and aes_top
// Optional strict framing on s_tlast: AES_STREAM_TLAST_CHECK_EN
module aes_stream_ctrl (
  input  logic              clk,
  input  logic              reset,
  aes_stream_ctrl_if.master bus
);
  localparam int WORD_S = 32;
  localparam int KEY_S  = 128;
  localparam int BLK_S  = 128;

  localparam logic [WORD_S-1:0] CMD_SET_KEY = 32'h0000_0001;
  localparam logic [WORD_S-1:0] CMD_ENCRYPT = 32'h0000_0002;
  localparam logic [WORD_S-1:0] CMD_DECRYPT = 32'h0000_0003;

  typedef enum logic [2:0] {
    S_CMD,
    S_PAYLOAD,
    S_START,
    S_WAIT,
    S_OUT
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WORD_S-1:0] r_cmd;
  logic [KEY_S-1:0]  r_key;
  logic [BLK_S-1:0]  r_blk;
  logic [BLK_S-1:0]  r_out;
  logic [95:0]       r_shift;
  logic [1:0]        r_cnt;
  logic              r_frame_err;

  logic              w_s_ready;
  logic              w_s_hs;
  logic              w_last_word;
  logic              w_cmd_ok;
  logic              w_abort;
  logic [WORD_S-1:0] w_out_word;

  assign w_s_ready   = (r_state == S_CMD) || (r_state == S_PAYLOAD);
  assign w_s_hs      = bus.s_tvalid && w_s_ready;
  assign w_last_word = (r_cnt == 2'd3);
  assign w_cmd_ok    = (r_cmd == CMD_SET_KEY) || (r_cmd == CMD_ENCRYPT) ||
                       (r_cmd == CMD_DECRYPT);

  always_comb begin
    w_abort = 1'b0;
`ifdef AES_STREAM_TLAST_CHECK_EN
    if (r_state == S_CMD)
      w_abort = w_s_hs && bus.s_tlast;
    else if (r_state == S_PAYLOAD)
      w_abort = w_s_hs && (bus.s_tlast != w_last_word);
`endif
  end

  always_comb begin
    case (r_cnt)
      2'd0:    w_out_word = r_out[127:96];
      2'd1:    w_out_word = r_out[95:64];
      2'd2:    w_out_word = r_out[63:32];
      default: w_out_word = r_out[31:0];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= S_CMD;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    bus.aes_en   = 1'b0;
    bus.m_tvalid = 1'b0;
    bus.m_tlast  = 1'b0;
    bus.m_tdata  = '0;
    case (r_state)
      S_CMD: begin
        if (w_s_hs && !w_abort)
          w_next = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        if (w_s_hs) begin
          if (w_abort)
            w_next = S_CMD;
          else if (w_last_word)
            w_next = w_cmd_ok ? S_START : S_CMD;
        end
      end
      S_START: begin
        bus.aes_en = 1'b1;
        w_next     = S_WAIT;
      end
      S_WAIT: begin
        if (bus.aes_en_o)
          w_next = (r_cmd == CMD_SET_KEY) ? S_CMD : S_OUT;
      end
      S_OUT: begin
        bus.m_tvalid = 1'b1;
        bus.m_tlast  = w_last_word;
        bus.m_tdata  = w_out_word;
        if (bus.m_tready && w_last_word)
          w_next = S_CMD;
      end
      default: w_next = S_CMD;
    endcase
  end

  // Payload collects in r_shift and commits on the 4th word, so aborted or
  // unknown frames never disturb the key or block seen by aes_top.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd       <= '0;
      r_key       <= '0;
      r_blk       <= '0;
      r_out       <= '0;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        S_CMD: begin
          if (w_s_hs) begin
            if (w_abort) begin
              r_frame_err <= 1'b1;
            end else begin
              r_cmd <= bus.s_tdata;
              r_cnt <= 2'd0;
            end
          end
        end
        S_PAYLOAD: begin
          if (w_s_hs) begin
            if (w_abort) begin
              r_frame_err <= 1'b1;
            end else begin
              r_cnt   <= r_cnt + 2'd1;
              r_shift <= {r_shift[63:0], bus.s_tdata};
              if (w_last_word) begin
                if (!w_cmd_ok)
                  r_frame_err <= 1'b1;
                else if (r_cmd == CMD_SET_KEY)
                  r_key <= {r_shift, bus.s_tdata};
                else
                  r_blk <= {r_shift, bus.s_tdata};
              end
            end
          end
        end
        S_WAIT: begin
          if (bus.aes_en_o) begin
            r_out <= bus.aes_out_blk;
            r_cnt <= 2'd0;
          end
        end
        S_OUT: begin
          if (bus.m_tready)
            r_cnt <= r_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.s_tready   = w_s_ready;
  assign bus.aes_cmd    = r_cmd;
  assign bus.aes_key    = r_key;
  assign bus.aes_in_blk = r_blk;
  assign bus.busy       = (r_state != S_CMD);
  assign bus.frame_err  = r_frame_err;
endmodule

// File: tb/tb_aes_stream_ctrl.sv
// tb/tb_aes_stream_ctrl.sv - self-checking bench for aes_stream_ctrl with a stub aes_top
module tb_aes_stream_ctrl;
  localparam logic [31:0]  C_SET_KEY = 32'h0000_0001;
  localparam logic [31:0]  C_ENC     = 32'h0000_0002;
  localparam logic [31:0]  C_DEC     = 32'h0000_0003;
  localparam logic [127:0] KEY_T = 128'h5468617473206d79204b756e67204675;
  localparam logic [127:0] PT_T  = 128'h54776f204f6e65204e696e652054776f;
  localparam logic [127:0] CT_T  = 128'h29c3505f571420f6402299b31a02d73a;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  aes_stream_ctrl_if bus();
  aes_stream_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [127:0] key_model = '0;

  int cyc = 0, en_cnt = 0, eno_cnt = 0, ferr_cnt = 0, mv_cnt = 0;
  int ferr_run = 0, ferr_maxw = 0, last_eno_cyc = 0, core_delay = 0;
  logic [31:0]  cap_cmd;
  logic [127:0] cap_key, cap_blk;
  bit in_wait = 0, stab_bad = 0;

  // Stand-in for aes_top: known FIPS-197-style vector, otherwise a cheap reversible mix.
  function automatic logic [127:0] core_f(input logic [31:0] c, input logic [127:0] k,
                                          input logic [127:0] b);
    if (c == C_ENC && k == KEY_T && b == PT_T) return CT_T;
    if (c == C_ENC) return b ^ k;
    return {b[63:0], b[127:64]} ^ ~k;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset) in_wait = 0;
    if (bus.aes_en) begin
      en_cnt++;
      cap_cmd = bus.aes_cmd; cap_key = bus.aes_key; cap_blk = bus.aes_in_blk;
      in_wait = 1;
    end else if (in_wait) begin
      if ({bus.aes_cmd, bus.aes_key, bus.aes_in_blk} !== {cap_cmd, cap_key, cap_blk})
        stab_bad = 1;
    end
    if (bus.aes_en_o) begin eno_cnt++; last_eno_cyc = cyc; in_wait = 0; end
    if (bus.m_tvalid) mv_cnt++;
    if (bus.frame_err) begin
      ferr_cnt++; ferr_run++;
      if (ferr_run > ferr_maxw) ferr_maxw = ferr_run;
    end else ferr_run = 0;
  end

  initial begin
    int d;
    logic [31:0] c; logic [127:0] k, b;
    bus.aes_en_o = 1'b0;
    bus.aes_out_blk = '0;
    forever begin
      @(negedge clk);
      if (bus.aes_en === 1'b1) begin
        c = bus.aes_cmd; k = bus.aes_key; b = bus.aes_in_blk;
        d = (core_delay > 0) ? core_delay : int'($urandom_range(1, 4));
        repeat (d) @(posedge clk);
        #1; bus.aes_en_o = 1'b1; bus.aes_out_blk = core_f(c, k, b);
        @(posedge clk); #1; bus.aes_en_o = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, output bit ok);
    ok = 0;
    bus.s_tdata = d; bus.s_tlast = last; bus.s_tvalid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.s_tready === 1'b1) begin ok = 1; break; end
    end
    step();
    bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] c, input logic [127:0] p, input bit gaps,
                            output bit ok);
    bit o;
    send_word(c, 1'b0, o); ok = o;
    for (int i = 0; i < 4; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) step();
      send_word(p[127-32*i -: 32], i == 3, o); ok &= o;
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) begin ok = 1; break; end
    end
    step();
  endtask

  // mode 0: always ready, 1: random ready, 2: five stall cycles on word 1
  task automatic recv_block(input int mode, output logic [127:0] words, output logic [3:0] lastv,
                            output int first_cyc, output int end_cyc, output bit srdy_bad,
                            output bit hold_bad, output bit ok);
    int k = 0, stall = 0;
    logic [31:0] held = '0;
    bit have_held = 0;
    words = '0; lastv = '0; first_cyc = 0; end_cyc = 0; srdy_bad = 0; hold_bad = 0;
    for (int t = 0; t < 400 && k < 4; t++) begin
      step();
      case (mode)
        0:       bus.m_tready = 1'b1;
        1:       bus.m_tready = ($urandom_range(0, 1) == 1);
        default: bus.m_tready = !(k == 1 && stall < 5);
      endcase
      @(negedge clk);
      if (bus.m_tvalid === 1'b1) begin
        if (bus.s_tready !== 1'b0) srdy_bad = 1;
        if (have_held && bus.m_tdata !== held) hold_bad = 1;
        if (bus.m_tready) begin
          words[127-32*k -: 32] = bus.m_tdata;
          lastv[k] = bus.m_tlast;
          if (k == 0) first_cyc = cyc;
          end_cyc = cyc;
          k++; have_held = 0;
        end else begin
          held = bus.m_tdata; have_held = 1;
          if (k == 1) stall++;
        end
      end
    end
    ok = (k == 4);
    step();
    bus.m_tready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.s_tready !== 1'b1) begin errors++; $display("FAIL reset_s_tready got=%b exp=1", bus.s_tready); end
    checks++; if ({bus.m_tvalid, bus.m_tlast, bus.m_tdata} !== 34'd0) begin errors++; $display("FAIL reset_m got=%b%b %h exp=0", bus.m_tvalid, bus.m_tlast, bus.m_tdata); end
    checks++; if ({bus.aes_en, bus.busy, bus.frame_err} !== 3'd0) begin errors++; $display("FAIL reset_ctl got=%b%b%b exp=000", bus.aes_en, bus.busy, bus.frame_err); end
    checks++; if ({bus.aes_cmd, bus.aes_key, bus.aes_in_blk} !== 288'd0) begin errors++; $display("FAIL reset_operands got=%h %h %h exp=0", bus.aes_cmd, bus.aes_key, bus.aes_in_blk); end
    @(negedge clk); reset = 1'b0;
    step();
  endtask

  task automatic test_set_key();
    int e0 = en_cnt, v0 = mv_cnt;
    bit ok;
    send_frame(C_SET_KEY, KEY_T, 1'b0, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL setkey_accept got=%b exp=1", ok); end
    checks++; if (bus.aes_en !== 1'b1) begin errors++; $display("FAIL setkey_en_latency got=%b exp=1", bus.aes_en); end
    checks++; if (bus.aes_key !== KEY_T) begin errors++; $display("FAIL setkey_key got=%h exp=%h", bus.aes_key, KEY_T); end
    wait_idle(ok);
    repeat (3) step();
    key_model = KEY_T;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL setkey_idle got=%b exp=1", ok); end
    checks++; if (en_cnt - e0 !== 1) begin errors++; $display("FAIL setkey_en_count got=%0d exp=1", en_cnt - e0); end
    checks++; if (mv_cnt - v0 !== 0) begin errors++; $display("FAIL setkey_no_output got=%0d exp=0", mv_cnt - v0); end
    checks++; if (bus.s_tready !== 1'b1) begin errors++; $display("FAIL setkey_back_cmd got=%b exp=1", bus.s_tready); end
  endtask

  task automatic test_encrypt();
    logic [127:0] w; logic [3:0] lv; int fc, lc; bit sb, hb, ok;
    stab_bad = 0;
    send_frame(C_ENC, PT_T, 1'b0, ok);
    recv_block(0, w, lv, fc, lc, sb, hb, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL enc_done got=%b exp=1", ok); end
    checks++; if (w !== CT_T) begin errors++; $display("FAIL enc_data got=%h exp=%h", w, CT_T); end
    checks++; if (lv !== 4'b1000) begin errors++; $display("FAIL enc_tlast got=%b exp=1000", lv); end
    checks++; if (lc - fc !== 3) begin errors++; $display("FAIL enc_burst got=%0d exp=3", lc - fc); end
    checks++; if (fc - last_eno_cyc !== 1) begin errors++; $display("FAIL enc_out_latency got=%0d exp=1", fc - last_eno_cyc); end
    checks++; if (cap_blk !== PT_T || cap_cmd !== C_ENC) begin errors++; $display("FAIL enc_operands got=%h %h exp=%h %h", cap_cmd, cap_blk, C_ENC, PT_T); end
    checks++; if (stab_bad !== 1'b0) begin errors++; $display("FAIL enc_stable got=%b exp=0", stab_bad); end
  endtask

  task automatic test_backpressure();
    logic [127:0] w, p, exp; logic [3:0] lv; int fc, lc; bit sb, hb, ok;
    p = {$urandom, $urandom, $urandom, $urandom};
    exp = core_f(C_DEC, key_model, p);
    send_frame(C_DEC, p, 1'b1, ok);
    recv_block(2, w, lv, fc, lc, sb, hb, ok);
    checks++; if (w !== exp) begin errors++; $display("FAIL bp_data got=%h exp=%h", w, exp); end
    checks++; if (hb !== 1'b0) begin errors++; $display("FAIL bp_hold got=%b exp=0", hb); end
    checks++; if (sb !== 1'b0) begin errors++; $display("FAIL bp_s_tready got=%b exp=0", sb); end
    checks++; if (lc - fc !== 8) begin errors++; $display("FAIL bp_span got=%0d exp=8", lc - fc); end
  endtask

  task automatic test_unknown();
    logic [127:0] w, p; logic [3:0] lv; int fc, lc; bit sb, hb, ok;
    int e0 = en_cnt, f0 = ferr_cnt;
    ferr_maxw = 0;
    send_frame(32'hFFFF_FFFF, {$urandom, $urandom, $urandom, $urandom}, 1'b0, ok);
    checks++; if (bus.frame_err !== 1'b1 || bus.aes_en !== 1'b0) begin errors++; $display("FAIL unk_pulse got=%b%b exp=10", bus.frame_err, bus.aes_en); end
    repeat (4) step();
    checks++; if (en_cnt - e0 !== 0) begin errors++; $display("FAIL unk_no_en got=%0d exp=0", en_cnt - e0); end
    checks++; if (ferr_cnt - f0 !== 1 || ferr_maxw !== 1) begin errors++; $display("FAIL unk_err_width got=%0d/%0d exp=1/1", ferr_cnt - f0, ferr_maxw); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL unk_idle got=%b exp=0", bus.busy); end
    p = {$urandom, $urandom, $urandom, $urandom};
    send_frame(C_ENC, p, 1'b0, ok);
    recv_block(0, w, lv, fc, lc, sb, hb, ok);
    checks++; if (w !== core_f(C_ENC, key_model, p)) begin errors++; $display("FAIL unk_next_enc got=%h exp=%h", w, core_f(C_ENC, key_model, p)); end
  endtask

  task automatic test_random();
    logic [127:0] w, p; logic [3:0] lv; logic [31:0] c; int fc, lc, sel, e0, f0; bit sb, hb, ok;
    for (int n = 0; n < 24; n++) begin
      sel = $urandom_range(0, 3);
      p = {$urandom, $urandom, $urandom, $urandom};
      c = (sel == 0) ? C_SET_KEY : (sel == 1) ? C_ENC : (sel == 2) ? C_DEC : ($urandom | 32'h8000_0000);
      e0 = en_cnt; f0 = ferr_cnt;
      send_frame(c, p, 1'b1, ok);
      if (sel == 0) begin
        wait_idle(ok);
        key_model = p;
        checks++; if (bus.aes_key !== key_model || en_cnt - e0 !== 1) begin errors++; $display("FAIL rnd_setkey_%0d got=%h/%0d exp=%h/1", n, bus.aes_key, en_cnt - e0, key_model); end
      end else if (sel == 3) begin
        repeat (2) step();
        checks++; if (ferr_cnt - f0 !== 1 || en_cnt - e0 !== 0) begin errors++; $display("FAIL rnd_unknown_%0d got=%0d/%0d exp=1/0", n, ferr_cnt - f0, en_cnt - e0); end
      end else begin
        recv_block(1, w, lv, fc, lc, sb, hb, ok);
        checks++; if (w !== core_f(c, key_model, p) || lv !== 4'b1000) begin errors++; $display("FAIL rnd_data_%0d got=%h %b exp=%h 1000", n, w, lv, core_f(c, key_model, p)); end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [127:0] w, p; logic [3:0] lv; int fc, lc, eno0, v0; bit sb, hb, ok;
    core_delay = 12;
    send_frame(C_ENC, {$urandom, $urandom, $urandom, $urandom}, 1'b0, ok);
    repeat (3) step();
    checks++; if (bus.busy !== 1'b1 || bus.s_tready !== 1'b0) begin errors++; $display("FAIL rst_in_wait got=%b%b exp=10", bus.busy, bus.s_tready); end
    eno0 = eno_cnt; v0 = mv_cnt;
    reset = 1'b1;
    #1;
    checks++; if ({bus.s_tready, bus.m_tvalid, bus.m_tlast, bus.m_tdata, bus.aes_en, bus.busy, bus.frame_err} !== {1'b1, 37'd0}) begin errors++; $display("FAIL rst_async_ctl got=%b%b%b %h %b%b%b exp=100 0 000", bus.s_tready, bus.m_tvalid, bus.m_tlast, bus.m_tdata, bus.aes_en, bus.busy, bus.frame_err); end
    checks++; if ({bus.aes_cmd, bus.aes_key, bus.aes_in_blk} !== 288'd0) begin errors++; $display("FAIL rst_async_operands got=%h %h %h exp=0", bus.aes_cmd, bus.aes_key, bus.aes_in_blk); end
    @(negedge clk); reset = 1'b0;
    repeat (20) step();
    core_delay = 0;
    key_model = '0;
    checks++; if (eno_cnt - eno0 !== 1 || mv_cnt - v0 !== 0) begin errors++; $display("FAIL rst_stale_eno got=%0d/%0d exp=1/0", eno_cnt - eno0, mv_cnt - v0); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_idle got=%b exp=0", bus.busy); end
    p = {$urandom, $urandom, $urandom, $urandom};
    send_frame(C_ENC, p, 1'b0, ok);
    recv_block(0, w, lv, fc, lc, sb, hb, ok);
    checks++; if (w !== core_f(C_ENC, '0, p)) begin errors++; $display("FAIL rst_key_cleared got=%h exp=%h", w, core_f(C_ENC, '0, p)); end
  endtask

  task automatic test_tlast();
    logic [127:0] w, p; logic [3:0] lv; int fc, lc, e0, f0; bit sb, hb, ok;
    p = {$urandom, $urandom, $urandom, $urandom};
    e0 = en_cnt; f0 = ferr_cnt;
`ifdef AES_STREAM_TLAST_CHECK_EN
    send_word(C_ENC, 1'b0, ok);
    send_word(p[127:96], 1'b0, ok);
    send_word(p[95:64], 1'b1, ok);
    checks++; if (bus.frame_err !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL tlast_early got=%b%b exp=10", bus.frame_err, bus.busy); end
    send_word(C_DEC, 1'b0, ok);
    for (int i = 0; i < 4; i++) send_word(p[127-32*i -: 32], 1'b0, ok);
    checks++; if (bus.frame_err !== 1'b1 || bus.aes_en !== 1'b0) begin errors++; $display("FAIL tlast_missing got=%b%b exp=10", bus.frame_err, bus.aes_en); end
    repeat (3) step();
    checks++; if (ferr_cnt - f0 !== 2 || en_cnt - e0 !== 0) begin errors++; $display("FAIL tlast_counts got=%0d/%0d exp=2/0", ferr_cnt - f0, en_cnt - e0); end
    send_frame(C_ENC, p, 1'b0, ok);
`else
    send_word(C_ENC, 1'b0, ok);
    for (int i = 0; i < 4; i++) send_word(p[127-32*i -: 32], i == 1, ok);
    checks++; if (bus.aes_en !== 1'b1 || ferr_cnt - f0 !== 0) begin errors++; $display("FAIL tlast_ignored got=%b/%0d exp=1/0", bus.aes_en, ferr_cnt - f0); end
`endif
    recv_block(0, w, lv, fc, lc, sb, hb, ok);
    checks++; if (w !== core_f(C_ENC, key_model, p)) begin errors++; $display("FAIL tlast_after got=%h exp=%h", w, core_f(C_ENC, key_model, p)); end
  endtask

  initial begin
    bus.s_tdata = '0; bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0; bus.m_tready = 1'b0;
    test_reset();
    test_set_key();
    test_encrypt();
    test_backpressure();
    test_unknown();
    test_random();
    test_reset_mid_wait();
    test_tlast();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
